pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: decodes load-use hazards, taken branches and
// data-memory waits into register enables, bubble flushes and PC select.
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_memread,
    input  logic             ex_mem_branch,
    input  logic             ex_mem_zero,
    input  logic             ex_mem_memop,
    input  logic             dmem_ack,
    output logic             en_pc,
    output logic             en_if_id,
    output logic             en_id_ex,
    output logic             en_ex_mem,
    output logic             en_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             pc_sel,
    output logic [1:0]       state,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_LSTALL = 2'd1;
    localparam logic [1:0] ST_MWAIT  = 2'd2;

    localparam int              WC_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    logic [1:0]      state_reg, state_next;
    logic [WC_W-1:0] wait_reg, wait_next;
    logic            err_reg, err_next;
    logic [4:0]      en_vec;    // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [2:0]      fl_vec;    // {if_id, id_ex, ex_mem}
    logic            pc_sel_c;
    logic [1:0]      cnt_inc;   // {flush, stall}
    logic [CNT_W-1:0] cnt_reg [2];

    logic hazard, taken, mwait_req;

    assign hazard    = id_ex_memread && (id_ex_rd != 5'd0) &&
                       ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
    assign taken     = ex_mem_branch && ex_mem_zero;
    assign mwait_req = ex_mem_memop && !dmem_ack;

    always_comb begin
        en_vec     = 5'b11111;
        fl_vec     = 3'b000;
        pc_sel_c   = 1'b0;
        state_next = ST_RUN;
        wait_next  = wait_reg;
        err_next   = err_reg;
        cnt_inc    = 2'b00;
        if (srst) begin
            fl_vec = 3'b111;
        end else begin
            case (state_reg)
                ST_RUN, ST_LSTALL, ST_MWAIT: begin
                    if (state_reg == ST_MWAIT && !dmem_ack) begin
                        cnt_inc[0] = 1'b1;
                        if (wait_reg == WC_LAST) begin
                            // Abort: squash the stuck access and let the rest resume later
                            err_next = 1'b1;
                            en_vec   = 5'b00010;
                            fl_vec   = 3'b001;
                        end else begin
                            en_vec     = 5'b00000;
                            wait_next  = wait_reg + 1'b1;
                            state_next = ST_MWAIT;
                        end
                    end else if (mwait_req) begin
                        en_vec     = 5'b00000;
                        wait_next  = '0;
                        state_next = ST_MWAIT;
                    end else if (taken) begin
                        pc_sel_c   = 1'b1;
                        fl_vec     = 3'b111;
                        cnt_inc[1] = 1'b1;
                    end else if (hazard && state_reg != ST_LSTALL) begin
                        en_vec     = 5'b00111;
                        fl_vec     = 3'b010;
                        cnt_inc[0] = 1'b1;
                        state_next = ST_LSTALL;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= ST_RUN;
            wait_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            err_reg   <= err_next;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (srst) begin
                cnt_reg[gi] <= '0;
            end else if (cnt_inc[gi] && cnt_reg[gi] != {CNT_W{1'b1}}) begin
                cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
            end
        end
    end

    assign {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb} = en_vec;
    assign {flush_if_id, flush_id_ex, flush_ex_mem}          = fl_vec;
    assign pc_sel    = pc_sel_c;
    assign state     = state_reg;
    assign mem_err   = err_reg;
    assign stall_cnt = cnt_reg[0];
    assign flush_cnt = cnt_reg[1];

endmodule
